multicycle_control_fsm: RTL and testbench

Main control state machine of the multicycle RISC-V core. It sequences fetch, decode, execute, memory and write-back for each instruction, and drives every datapath enable and mux select. This includes PcWriteCond and BranchType, which feed the branch selector that gates conditional PC updates. It also waits on a memory ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/riscv_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm_decoder.sv | 128 ++++++++++++
 rtl/multicycle_control_fsm.sv | 142 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// Holds the state encoding, the opcode constants, the branch-type codes,
// the datapath select codes and small decode helpers used by the FSM and
// by its output decoder.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_FAULT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_NE = 2'd1;
  localparam logic [1:0] BR_GE = 2'd2;
  localparam logic [1:0] BR_LT = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MDR = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;
  localparam logic [1:0] MTR_IMM = 2'd3;

  // Only BEQ, BNE, BLT and BGE are supported; BLTU/BGEU and the reserved
  // encodings are treated as illegal.
  function automatic logic isBranchF3(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic isLegalInstr(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_LUI: return 1'b1;
      OP_BRANCH:                                             return isBranchF3(f3);
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] branchType(input logic [2:0] f3);
    case (f3)
      3'b001:  return BR_NE;
      3'b101:  return BR_GE;
      3'b100:  return BR_LT;
      default: return BR_EQ;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// ctrl_output_decoder: purely combinational map from the current FSM state
// (plus MemReady, Opcode, Funct3 for the Mealy terms) to every datapath
// enable and mux select of the multicycle core.
// Inputs : state, MemReady, Opcode, Funct3
// Outputs: PC/memory/register enables, ALU and write-back selects,
//          BranchType, IllegalInstr pulse, MemFault.
module ctrl_output_decoder
  import riscv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       MemReady,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic [1:0] BranchType,
  output logic       PcSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IrWrite,
  output logic       OldPcWrite,
  output logic       MdrWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] MemToReg,
  output logic       IllegalInstr,
  output logic       MemFault
);

  always_comb begin
    PcWrite      = 1'b0;
    PcWriteCond  = 1'b0;
    BranchType   = BR_EQ;
    PcSource     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IrWrite      = 1'b0;
    OldPcWrite   = 1'b0;
    MdrWrite     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    ALUOp        = ALUOP_ADD;
    MemToReg     = MTR_ALU;
    IllegalInstr = 1'b0;
    MemFault     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IorD    = 1'b0;
        // Instruction lands this cycle: latch IR/OldPC and bump PC by 4.
        if (MemReady) begin
          IrWrite    = 1'b1;
          OldPcWrite = 1'b1;
          PcWrite    = 1'b1;
          ALUSrcA    = SRCA_PC;
          ALUSrcB    = SRCB_FOUR;
          ALUOp      = ALUOP_ADD;
          PcSource   = 1'b0;
        end
      end
      S_DECODE: begin
        // Precompute OldPC + imm as the branch/jump target.
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_IMM;
        ALUOp        = ALUOP_ADD;
        IllegalInstr = !isLegalInstr(Opcode, Funct3);
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        MdrWrite = MemReady;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = MTR_MDR;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ITYPE;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        MemToReg = MTR_ALU;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_REG;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_CMP;
        PcWriteCond = 1'b1;
        PcSource    = 1'b1;
        BranchType  = branchType(Funct3);
      end
      S_JAL: begin
        RegWrite = 1'b1;
        MemToReg = MTR_PC;
        PcWrite  = 1'b1;
        PcSource = 1'b1;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemToReg = MTR_IMM;
      end
      S_FAULT: MemFault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multicycle RISC-V core.
// Sequences fetch/decode/execute/memory/write-back, waits on the MemReady
// handshake, and enters a sticky FAULT state when a memory access waits
// MEM_TIMEOUT consecutive cycles.
// Inputs : clk, rst_n (async, active-low), Opcode, Funct3, MemReady
// Outputs: all datapath enables/selects (from ctrl_output_decoder),
//          IllegalInstr, MemFault, State (debug).
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       MemReady,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic [1:0] BranchType,
  output logic       PcSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IrWrite,
  output logic       OldPcWrite,
  output logic       MdrWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] MemToReg,
  output logic       IllegalInstr,
  output logic       MemFault,
  output logic [3:0] State
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             memWait;
  logic             timeoutHit;

  logic       decPcWrite, decPcWriteCond, decPcSource, decIorD, decMemRead;
  logic       decMemWrite, decIrWrite, decOldPcWrite, decMdrWrite, decRegWrite;
  logic       decIllegalInstr, decMemFault;
  logic [1:0] decBranchType, decALUSrcA, decALUSrcB, decALUOp, decMemToReg;

  assign memWait = ((state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE))
                   && !MemReady;
  // Fault when this wait cycle would bring the count up to MEM_TIMEOUT; a
  // MemReady on that same cycle is a normal completion.
  assign timeoutHit = memWait && (waitCnt >= CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH:     if (MemReady) stateNext = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: stateNext = S_MEM_ADDR;
          OP_RTYPE:          stateNext = S_EXEC_R;
          OP_ITYPE:          stateNext = S_EXEC_I;
          OP_BRANCH:         stateNext = isBranchF3(Funct3) ? S_BRANCH : S_FETCH;
          OP_JAL:            stateNext = S_JAL;
          OP_LUI:            stateNext = S_LUI;
          default:           stateNext = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  stateNext = (Opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (MemReady) stateNext = S_MEM_WB;
      S_MEM_WRITE: if (MemReady) stateNext = S_FETCH;
      S_EXEC_R, S_EXEC_I: stateNext = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_LUI: stateNext = S_FETCH;
      S_FAULT:     stateNext = S_FAULT;
      default:     stateNext = S_FETCH;
    endcase
    if (timeoutHit) stateNext = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (memWait) begin
        if (waitCnt != CNT_W'(MEM_TIMEOUT)) waitCnt <= waitCnt + CNT_W'(1);
      end else begin
        waitCnt <= '0;
      end
    end
  end

  ctrl_output_decoder uDecoder (
    .state        (state),
    .MemReady     (MemReady),
    .Opcode       (Opcode),
    .Funct3       (Funct3),
    .PcWrite      (decPcWrite),
    .PcWriteCond  (decPcWriteCond),
    .BranchType   (decBranchType),
    .PcSource     (decPcSource),
    .IorD         (decIorD),
    .MemRead      (decMemRead),
    .MemWrite     (decMemWrite),
    .IrWrite      (decIrWrite),
    .OldPcWrite   (decOldPcWrite),
    .MdrWrite     (decMdrWrite),
    .RegWrite     (decRegWrite),
    .ALUSrcA      (decALUSrcA),
    .ALUSrcB      (decALUSrcB),
    .ALUOp        (decALUOp),
    .MemToReg     (decMemToReg),
    .IllegalInstr (decIllegalInstr),
    .MemFault     (decMemFault)
  );

  // The decoder is Mealy in FETCH, so outputs are gated by rst_n directly to
  // keep every strobe low for the whole time reset is held.
  assign PcWrite      = rst_n & decPcWrite;
  assign PcWriteCond  = rst_n & decPcWriteCond;
  assign BranchType   = {2{rst_n}} & decBranchType;
  assign PcSource     = rst_n & decPcSource;
  assign IorD         = rst_n & decIorD;
  assign MemRead      = rst_n & decMemRead;
  assign MemWrite     = rst_n & decMemWrite;
  assign IrWrite      = rst_n & decIrWrite;
  assign OldPcWrite   = rst_n & decOldPcWrite;
  assign MdrWrite     = rst_n & decMdrWrite;
  assign RegWrite     = rst_n & decRegWrite;
  assign ALUSrcA      = {2{rst_n}} & decALUSrcA;
  assign ALUSrcB      = {2{rst_n}} & decALUSrcB;
  assign ALUOp        = {2{rst_n}} & decALUOp;
  assign MemToReg     = {2{rst_n}} & decMemToReg;
  assign IllegalInstr = rst_n & decIllegalInstr;
  assign MemFault     = rst_n & decMemFault;
  assign State        = {4{rst_n}} & state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  typedef logic [21:0] ov_t;
  typedef struct {
    logic [3:0] st;
    ov_t        o;
    string      tag;
  } exp_t;

  // Output vector layout:
  // [21] PcWrite [20] PcWriteCond [19:18] BranchType [17] PcSource [16] IorD
  // [15] MemRead [14] MemWrite [13] IrWrite [12] OldPcWrite [11] MdrWrite
  // [10] RegWrite [9:8] ALUSrcA [7:6] ALUSrcB [5:4] ALUOp [3:2] MemToReg
  // [1] IllegalInstr [0] MemFault
  localparam ov_t O_PCW   = ov_t'(1) << 21;
  localparam ov_t O_PCWC  = ov_t'(1) << 20;
  localparam ov_t O_PCSRC = ov_t'(1) << 17;
  localparam ov_t O_IORD  = ov_t'(1) << 16;
  localparam ov_t O_MRD   = ov_t'(1) << 15;
  localparam ov_t O_MWR   = ov_t'(1) << 14;
  localparam ov_t O_IRW   = ov_t'(1) << 13;
  localparam ov_t O_OPCW  = ov_t'(1) << 12;
  localparam ov_t O_MDRW  = ov_t'(1) << 11;
  localparam ov_t O_REGW  = ov_t'(1) << 10;
  localparam ov_t O_ILL   = ov_t'(1) << 1;
  localparam ov_t O_FLT   = ov_t'(1) << 0;

  localparam ov_t E_NONE      = '0;
  localparam ov_t E_FETCHWAIT = O_MRD;
  localparam ov_t E_FETCHDONE = O_MRD | O_IRW | O_OPCW | O_PCW | (ov_t'(1) << 6);
  localparam ov_t E_DECODE    = (ov_t'(2) << 8) | (ov_t'(2) << 6);
  localparam ov_t E_MEMADDR   = (ov_t'(1) << 8) | (ov_t'(2) << 6);
  localparam ov_t E_MEMRDWAIT = O_MRD | O_IORD;
  localparam ov_t E_MEMRDDONE = O_MRD | O_IORD | O_MDRW;
  localparam ov_t E_MEMWB     = O_REGW | (ov_t'(1) << 2);
  localparam ov_t E_MEMWRITE  = O_MWR | O_IORD;
  localparam ov_t E_EXECR     = (ov_t'(1) << 8) | (ov_t'(2) << 4);
  localparam ov_t E_EXECI     = (ov_t'(1) << 8) | (ov_t'(2) << 6) | (ov_t'(3) << 4);
  localparam ov_t E_ALUWB     = O_REGW;
  localparam ov_t E_BRANCH    = (ov_t'(1) << 8) | (ov_t'(1) << 4) | O_PCWC | O_PCSRC;
  localparam ov_t E_JAL       = O_REGW | (ov_t'(2) << 2) | O_PCW | O_PCSRC;
  localparam ov_t E_LUI       = O_REGW | (ov_t'(3) << 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       MemReady;
  logic       PcWrite, PcWriteCond, PcSource, IorD, MemRead, MemWrite;
  logic       IrWrite, OldPcWrite, MdrWrite, RegWrite, IllegalInstr, MemFault;
  logic [1:0] BranchType, ALUSrcA, ALUSrcB, ALUOp, MemToReg;
  logic [3:0] State;
  ov_t        obs;

  exp_t expQ[$];
  int   nAsserts = 0;
  int   nFails   = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Opcode       (Opcode),
    .Funct3       (Funct3),
    .MemReady     (MemReady),
    .PcWrite      (PcWrite),
    .PcWriteCond  (PcWriteCond),
    .BranchType   (BranchType),
    .PcSource     (PcSource),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IrWrite      (IrWrite),
    .OldPcWrite   (OldPcWrite),
    .MdrWrite     (MdrWrite),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .MemToReg     (MemToReg),
    .IllegalInstr (IllegalInstr),
    .MemFault     (MemFault),
    .State        (State)
  );

  assign obs = {PcWrite, PcWriteCond, BranchType, PcSource, IorD, MemRead, MemWrite,
                IrWrite, OldPcWrite, MdrWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                MemToReg, IllegalInstr, MemFault};

  task automatic pushExp(input logic [3:0] st, input ov_t o, input string tag);
    exp_t e;
    e.st  = st;
    e.o   = o;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    if (expQ.size() == 0) begin
      nAsserts++;
      nFails++;
      $display("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e = expQ.pop_front();
    nAsserts++;
    assert (State === e.st) else begin
      nFails++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, State, e.st);
    end
    nAsserts++;
    assert (obs === e.o) else begin
      nFails++;
      $error("FAIL %s outputs: observed %h expected %h", e.tag, obs, e.o);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                     input state_t st, input ov_t o, input string tag);
    Opcode   = op;
    Funct3   = f3;
    MemReady = rdy;
    pushExp(st, o, tag);
    @(negedge clk);
    popCheck();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    Opcode   = OP_RTYPE;
    Funct3   = 3'b000;
    MemReady = 1'b1;
    #2;
    pushExp(S_FETCH, E_NONE, "reset_async");
    popCheck();
    @(posedge clk);
    #1;
    cyc(OP_RTYPE, 3'b000, 1'b1, S_FETCH, E_NONE, "reset_held");
    rst_n = 1'b1;

    // R-type, memory always ready
    cyc(OP_RTYPE, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "r_fetch");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_DECODE, E_DECODE,    "r_decode");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_EXEC_R, E_EXECR,     "r_exec");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_ALU_WB, E_ALUWB,     "r_wb");

    // Load with 3 wait cycles in MEM_READ: 8 cycles total
    cyc(OP_LOAD, 3'b010, 1'b1, S_FETCH,    E_FETCHDONE, "ld_fetch");
    cyc(OP_LOAD, 3'b010, 1'b1, S_DECODE,   E_DECODE,    "ld_decode");
    cyc(OP_LOAD, 3'b010, 1'b1, S_MEM_ADDR, E_MEMADDR,   "ld_addr");
    cyc(OP_LOAD, 3'b010, 1'b0, S_MEM_READ, E_MEMRDWAIT, "ld_wait1");
    cyc(OP_LOAD, 3'b010, 1'b0, S_MEM_READ, E_MEMRDWAIT, "ld_wait2");
    cyc(OP_LOAD, 3'b010, 1'b0, S_MEM_READ, E_MEMRDWAIT, "ld_wait3");
    cyc(OP_LOAD, 3'b010, 1'b1, S_MEM_READ, E_MEMRDDONE, "ld_done");
    cyc(OP_LOAD, 3'b010, 1'b1, S_MEM_WB,   E_MEMWB,     "ld_wb");

    // Branches: BLT, BGE, BNE
    cyc(OP_BRANCH, 3'b100, 1'b1, S_FETCH,  E_FETCHDONE, "blt_fetch");
    cyc(OP_BRANCH, 3'b100, 1'b1, S_DECODE, E_DECODE,    "blt_decode");
    cyc(OP_BRANCH, 3'b100, 1'b1, S_BRANCH, E_BRANCH | (ov_t'(3) << 18), "blt_branch");
    cyc(OP_BRANCH, 3'b101, 1'b1, S_FETCH,  E_FETCHDONE, "bge_fetch");
    cyc(OP_BRANCH, 3'b101, 1'b1, S_DECODE, E_DECODE,    "bge_decode");
    cyc(OP_BRANCH, 3'b101, 1'b1, S_BRANCH, E_BRANCH | (ov_t'(2) << 18), "bge_branch");
    cyc(OP_BRANCH, 3'b001, 1'b1, S_FETCH,  E_FETCHDONE, "bne_fetch");
    cyc(OP_BRANCH, 3'b001, 1'b1, S_DECODE, E_DECODE,    "bne_decode");
    cyc(OP_BRANCH, 3'b001, 1'b1, S_BRANCH, E_BRANCH | (ov_t'(1) << 18), "bne_branch");

    // Illegal opcode and illegal branch funct3
    cyc(7'b1110011, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE,      "ill_fetch");
    cyc(7'b1110011, 3'b000, 1'b1, S_DECODE, E_DECODE | O_ILL, "ill_decode");
    cyc(OP_BRANCH,  3'b010, 1'b1, S_FETCH,  E_FETCHDONE,      "illbr_fetch");
    cyc(OP_BRANCH,  3'b010, 1'b1, S_DECODE, E_DECODE | O_ILL, "illbr_decode");

    // Store interrupted by reset while waiting in MEM_WRITE
    cyc(OP_STORE, 3'b010, 1'b1, S_FETCH,     E_FETCHDONE, "st_fetch");
    cyc(OP_STORE, 3'b010, 1'b1, S_DECODE,    E_DECODE,    "st_decode");
    cyc(OP_STORE, 3'b010, 1'b1, S_MEM_ADDR,  E_MEMADDR,   "st_addr");
    cyc(OP_STORE, 3'b010, 1'b0, S_MEM_WRITE, E_MEMWRITE,  "st_wait1");
    cyc(OP_STORE, 3'b010, 1'b0, S_MEM_WRITE, E_MEMWRITE,  "st_wait2");
    rst_n = 1'b0;
    #1;
    pushExp(S_FETCH, E_NONE, "st_reset_now");
    popCheck();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // I-type after the aborted store
    cyc(OP_ITYPE, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "i_fetch");
    cyc(OP_ITYPE, 3'b000, 1'b1, S_DECODE, E_DECODE,    "i_decode");
    cyc(OP_ITYPE, 3'b000, 1'b1, S_EXEC_I, E_EXECI,     "i_exec");
    cyc(OP_ITYPE, 3'b000, 1'b1, S_ALU_WB, E_ALUWB,     "i_wb");

    // JAL and LUI
    cyc(OP_JAL, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "jal_fetch");
    cyc(OP_JAL, 3'b000, 1'b1, S_DECODE, E_DECODE,    "jal_decode");
    cyc(OP_JAL, 3'b000, 1'b1, S_JAL,    E_JAL,       "jal_exec");
    cyc(OP_LUI, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "lui_fetch");
    cyc(OP_LUI, 3'b000, 1'b1, S_DECODE, E_DECODE,    "lui_decode");
    cyc(OP_LUI, 3'b000, 1'b1, S_LUI,    E_LUI,       "lui_exec");

    // Complete store
    cyc(OP_STORE, 3'b010, 1'b1, S_FETCH,     E_FETCHDONE, "st2_fetch");
    cyc(OP_STORE, 3'b010, 1'b1, S_DECODE,    E_DECODE,    "st2_decode");
    cyc(OP_STORE, 3'b010, 1'b1, S_MEM_ADDR,  E_MEMADDR,   "st2_addr");
    cyc(OP_STORE, 3'b010, 1'b1, S_MEM_WRITE, E_MEMWRITE,  "st2_write");

    // Ready arrives on the cycle the count would hit the limit: no fault
    cyc(OP_LUI, 3'b000, 1'b0, S_FETCH,  E_FETCHWAIT, "edge_wait1");
    cyc(OP_LUI, 3'b000, 1'b0, S_FETCH,  E_FETCHWAIT, "edge_wait2");
    cyc(OP_LUI, 3'b000, 1'b0, S_FETCH,  E_FETCHWAIT, "edge_wait3");
    cyc(OP_LUI, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "edge_ready");
    cyc(OP_LUI, 3'b000, 1'b0, S_DECODE, E_DECODE,    "edge_decode");
    cyc(OP_LUI, 3'b000, 1'b0, S_LUI,    E_LUI,       "edge_lui");

    // Four wait cycles in FETCH lead to FAULT
    cyc(OP_RTYPE, 3'b000, 1'b0, S_FETCH, E_FETCHWAIT, "to_wait1");
    cyc(OP_RTYPE, 3'b000, 1'b0, S_FETCH, E_FETCHWAIT, "to_wait2");
    cyc(OP_RTYPE, 3'b000, 1'b0, S_FETCH, E_FETCHWAIT, "to_wait3");
    cyc(OP_RTYPE, 3'b000, 1'b0, S_FETCH, E_FETCHWAIT, "to_wait4");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_FAULT, O_FLT,       "fault1");
    cyc(OP_RTYPE, 3'b000, 1'b0, S_FAULT, O_FLT,       "fault2");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_FAULT, O_FLT,       "fault3");
    rst_n = 1'b0;
    #1;
    pushExp(S_FETCH, E_NONE, "fault_reset_now");
    popCheck();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(OP_RTYPE, 3'b000, 1'b1, S_FETCH,  E_FETCHDONE, "post_fault_fetch");
    cyc(OP_RTYPE, 3'b000, 1'b1, S_DECODE, E_DECODE,    "post_fault_decode");

    nAsserts++;
    assert (expQ.size() == 0) else begin
      nFails++;
      $error("FAIL scoreboard_drain: observed %0d leftover, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
